// File: rtl/bitonic_pkg.sv
// Shared constants and helpers for the bitonic merge-node blocks.
// Lane packing: lane k of a packed vector of W-bit lanes occupies
// bits [W*(k+1)-1 -: W], i.e. lane 0 is the least significant lane.
package bitonic_pkg;

  // Direction encoding carried on in_dir / out_dir.
  localparam logic DIR_DESC = 1'b1;  // larger key to the lower lane index
  localparam logic DIR_ASC  = 1'b0;  // smaller key to the lower lane index

  // Legal parameter ranges.
  localparam int NODE_ORDER_MIN = 1;
  localparam int NODE_ORDER_MAX = 6;
  localparam int PIPE_DEPTH_MIN = 1;
  localparam int PIPE_DEPTH_MAX = 4;

  // Most significant bit of lane idx in a vector of width-bit lanes.
  function automatic int lane_hi(input int width, input int idx);
    return width * (idx + 1) - 1;
  endfunction

  // Least significant bit of lane idx in a vector of width-bit lanes.
  function automatic int lane_lo(input int width, input int idx);
    return width * idx;
  endfunction

  function automatic bit node_order_legal(input int order);
    return (order >= NODE_ORDER_MIN) && (order <= NODE_ORDER_MAX);
  endfunction

  function automatic bit pipe_depth_legal(input int depth);
    return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/bitonic_cswap.sv
// One compare-exchange element of the half-cleaner. Purely combinational.
// Lane A is the lower-index lane of the pair, lane B the upper one.
// Ties never swap, so equal keys keep their original order (stable).
module bitonic_cswap
  import bitonic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic [DATA_WIDTH-1:0] a_key,
  input  logic [TAG_WIDTH-1:0]  a_tag,
  input  logic [DATA_WIDTH-1:0] b_key,
  input  logic [TAG_WIDTH-1:0]  b_tag,
  input  logic                  dir,
  output logic [DATA_WIDTH-1:0] lo_key,
  output logic [TAG_WIDTH-1:0]  lo_tag,
  output logic [DATA_WIDTH-1:0] hi_key,
  output logic [TAG_WIDTH-1:0]  hi_tag,
  output logic                  swap
);

  // Strict unsigned compare decides the exchange; tags follow their keys.
  always_comb begin
    swap   = (dir == DIR_DESC) ? (b_key > a_key) : (a_key > b_key);
    lo_key = swap ? b_key : a_key;
    lo_tag = swap ? b_tag : a_tag;
    hi_key = swap ? a_key : b_key;
    hi_tag = swap ? a_tag : b_tag;
  end

endmodule

// File: rtl/bitonic_node_pipe.sv
// Pipelined, flow-controlled bitonic half-cleaner for one merge level.
// Lane i is compare-exchanged against lane i+N/2 ahead of stage 1; the
// remaining stages are plain delay registers with bubble collapse.
//
// Handshake: a beat moves on every rising edge where valid && ready, on
// both the input and the output side. While out_valid && !out_ready the
// output registers hold. in_ready depends only on out_ready, the stage
// valid bits and reset -- never on in_valid -- so chained instances do not
// form combinational loops through valid.
module bitonic_node_pipe
  import bitonic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int NODE_ORDER = 3,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic                                  in_dir,
  input  logic [(2**NODE_ORDER)*DATA_WIDTH-1:0] in_key,
  input  logic [(2**NODE_ORDER)*TAG_WIDTH-1:0]  in_tag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [(2**NODE_ORDER)*DATA_WIDTH-1:0] out_key,
  output logic [(2**NODE_ORDER)*TAG_WIDTH-1:0]  out_tag,
  output logic                                  out_dir,
  output logic [(2**NODE_ORDER)/2-1:0]          out_swap
);

  localparam int N    = 2 ** NODE_ORDER;
  localparam int HALF = N / 2;
  localparam int KW   = N * DATA_WIDTH;
  localparam int TW   = N * TAG_WIDTH;
  localparam int LAST = PIPE_DEPTH - 1;

  // Reject illegal configurations at elaboration time.
  if (!node_order_legal(NODE_ORDER)) begin : g_bad_node_order
    $error("bitonic_node_pipe: NODE_ORDER out of range 1..6");
  end
  if (!pipe_depth_legal(PIPE_DEPTH)) begin : g_bad_pipe_depth
    $error("bitonic_node_pipe: PIPE_DEPTH out of range 1..4");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $error("bitonic_node_pipe: TAG_WIDTH must be at least 1");
  end

  // Exchanged lanes, ahead of stage 1.
  logic [KW-1:0]   xkey;
  logic [TW-1:0]   xtag;
  logic [HALF-1:0] xswap;

  for (genvar i = 0; i < HALF; i++) begin : g_cmp
    bitonic_cswap #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_cswap (
      .a_key  (in_key[lane_hi(DATA_WIDTH, i)        -: DATA_WIDTH]),
      .a_tag  (in_tag[lane_hi(TAG_WIDTH,  i)        -: TAG_WIDTH]),
      .b_key  (in_key[lane_hi(DATA_WIDTH, i + HALF) -: DATA_WIDTH]),
      .b_tag  (in_tag[lane_hi(TAG_WIDTH,  i + HALF) -: TAG_WIDTH]),
      .dir    (in_dir),
      .lo_key (xkey[lane_hi(DATA_WIDTH, i)          -: DATA_WIDTH]),
      .lo_tag (xtag[lane_hi(TAG_WIDTH,  i)          -: TAG_WIDTH]),
      .hi_key (xkey[lane_hi(DATA_WIDTH, i + HALF)   -: DATA_WIDTH]),
      .hi_tag (xtag[lane_hi(TAG_WIDTH,  i + HALF)   -: TAG_WIDTH]),
      .swap   (xswap[i])
    );
  end

  // Stage registers; index 0 is stage 1, index LAST drives the outputs.
  logic [PIPE_DEPTH-1:0] v_q,   v_d;
  logic [PIPE_DEPTH-1:0] dir_q, dir_d;
  logic [KW-1:0]         key_q  [PIPE_DEPTH];
  logic [KW-1:0]         key_d  [PIPE_DEPTH];
  logic [TW-1:0]         tag_q  [PIPE_DEPTH];
  logic [TW-1:0]         tag_d  [PIPE_DEPTH];
  logic [HALF-1:0]       swap_q [PIPE_DEPTH];
  logic [HALF-1:0]       swap_d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] load;

  // Stage load enables, walking back from the output: a stage may take new
  // contents when it is empty or when its own contents move on.
  always_comb begin
    load       = '0;
    load[LAST] = out_ready || !v_q[LAST];
    for (int s = LAST - 1; s >= 0; s--) begin
      load[s] = load[s + 1] || !v_q[s];
    end
  end

  assign in_ready = load[0] && !reset;

  // Next-state for every stage; data registers only change on a valid load
  // so an empty slot keeps its last contents.
  always_comb begin
    v_d    = v_q;
    dir_d  = dir_q;
    key_d  = key_q;
    tag_d  = tag_q;
    swap_d = swap_q;
    if (load[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        key_d[0]  = xkey;
        tag_d[0]  = xtag;
        dir_d[0]  = in_dir;
        swap_d[0] = xswap;
      end
    end
    for (int s = 1; s < PIPE_DEPTH; s++) begin
      if (load[s]) begin
        v_d[s] = v_q[s - 1];
        if (v_q[s - 1]) begin
          key_d[s]  = key_q[s - 1];
          tag_d[s]  = tag_q[s - 1];
          dir_d[s]  = dir_q[s - 1];
          swap_d[s] = swap_q[s - 1];
        end
      end
    end
  end

  // Pipeline state; reset discards every in-flight beat and clears data.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      dir_q <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        key_q[s]  <= '0;
        tag_q[s]  <= '0;
        swap_q[s] <= '0;
      end
    end else begin
      v_q    <= v_d;
      dir_q  <= dir_d;
      key_q  <= key_d;
      tag_q  <= tag_d;
      swap_q <= swap_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign out_key   = key_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_dir   = dir_q[LAST];
  assign out_swap  = swap_q[LAST];

endmodule

// File: tb/tb_bitonic_node_pipe.sv
// Bench for bitonic_node_pipe: directed cases and a random stream on the
// default configuration, plus random sweeps on two other configurations.
`timescale 1ns/1ps
module tb_bitonic_node_pipe;
  import bitonic_pkg::*;

  localparam int DW   = 8;
  localparam int TW   = 4;
  localparam int NO   = 3;
  localparam int PD   = 2;
  localparam int N    = 8;
  localparam int HALF = 4;
  localparam int EW   = N * DW + N * TW + 1 + HALF;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic              in_valid, in_ready, in_dir;
  logic [N*DW-1:0]   in_key;
  logic [N*TW-1:0]   in_tag;
  logic              out_valid, out_ready, out_dir;
  logic [N*DW-1:0]   out_key;
  logic [N*TW-1:0]   out_tag;
  logic [HALF-1:0]   out_swap;

  bitonic_node_pipe #(
    .DATA_WIDTH (DW), .TAG_WIDTH (TW), .NODE_ORDER (NO), .PIPE_DEPTH (PD)
  ) u_dut (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_ready (in_ready), .in_dir (in_dir),
    .in_key (in_key), .in_tag (in_tag),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_key (out_key), .out_tag (out_tag), .out_dir (out_dir),
    .out_swap (out_swap)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  logic sweep_go = 1'b0;
  logic main_done = 1'b0;

  logic [EW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: each upper/lower lane pair is ordered by direction, ties stay.
  function automatic logic [EW-1:0] model8(input logic [N*DW-1:0] k,
                                           input logic [N*TW-1:0] t,
                                           input logic d);
    logic [N*DW-1:0] rk;
    logic [N*TW-1:0] rt;
    logic [HALF-1:0] rs;
    int unsigned a, b;
    rk = k; rt = t; rs = '0;
    for (int i = 0; i < HALF; i++) begin
      a = k[i*DW +: DW];
      b = k[(i+HALF)*DW +: DW];
      if (d ? (b > a) : (a > b)) begin
        rk[i*DW +: DW]        = k[(i+HALF)*DW +: DW];
        rk[(i+HALF)*DW +: DW] = k[i*DW +: DW];
        rt[i*TW +: TW]        = t[(i+HALF)*TW +: TW];
        rt[(i+HALF)*TW +: TW] = t[i*TW +: TW];
        rs[i] = 1'b1;
      end
    end
    return {rk, rt, d, rs};
  endfunction

  function automatic logic [N*DW-1:0] rand_keys();
    logic [N*DW-1:0] k;
    for (int l = 0; l < N; l++)
      k[l*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3))
                                                   : DW'($urandom_range(0, 255));
    return k;
  endfunction

  // ---------------- scoreboard monitor (main DUT) ----------------
  int            occ = 0;
  bit            acc_f = 0, emi_f = 0, prev_stall = 0;
  logic [EW-1:0] prev_out;

  always @(negedge clk) begin
    logic [EW-1:0] act;
    act = {out_key, out_tag, out_dir, out_swap};
    chk("in_ready", in_ready, reset ? 1'b0 : !(occ == PD && !out_ready));
    if (!reset && prev_stall) chk("stall_hold", act, prev_out);
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
      else chk("out_beat", act, exp_q.pop_front());
    end
    acc_f      = !reset && in_valid && in_ready;
    emi_f      = !reset && out_valid && out_ready;
    prev_stall = !reset && out_valid && !out_ready;
    prev_out   = act;
  end

  always @(posedge clk) begin
    if (reset) occ = 0;
    else occ = occ + int'(acc_f) - int'(emi_f);
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [N*DW-1:0] k, input logic [N*TW-1:0] t, input logic d);
    in_valid = 1'b1; in_key = k; in_tag = t; in_dir = d;
    @(negedge clk);
    for (int w = 0; w < 100 && !in_ready; w++) @(negedge clk);
    if (!in_ready) chk("send_timeout", in_ready, 1'b1);
    else exp_q.push_back(model8(k, t, d));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Checks zero-stall latency and the exact result of the beat just sent.
  task automatic lat_check(input string nm, input logic [N*DW-1:0] ek,
                           input logic [N*TW-1:0] et, input logic ed, input logic [HALF-1:0] es);
    for (int k = 1; k <= PD; k++) begin
      @(negedge clk);
      chk({nm, "_out_valid"}, out_valid, (k == PD));
      if (k < PD) begin @(posedge clk); #1; end
    end
    chk({nm, "_key"},  out_key,  ek);
    chk({nm, "_tag"},  out_tag,  et);
    chk({nm, "_dir"},  out_dir,  ed);
    chk({nm, "_swap"}, out_swap, es);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string nm);
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
    chk(nm, exp_q.size(), 0);
    #1;
  endtask

  // ---------------- main sequence ----------------
  localparam logic [N*DW-1:0] K1   = 64'h05060708_04030201;
  localparam logic [N*TW-1:0] TIDX = 32'h76543210;

  initial begin
    in_valid = 1'b0; in_dir = 1'b0; in_key = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_key",   out_key,   '0);
    chk("rst_out_tag",   out_tag,   '0);
    chk("rst_out_dir",   out_dir,   1'b0);
    chk("rst_out_swap",  out_swap,  '0);
    chk("rst_in_ready",  in_ready,  1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Descending: every pair exchanges.
    send_beat(K1, TIDX, DIR_DESC);
    lat_check("t1", 64'h04030201_05060708, 32'h32107654, 1'b1, 4'b1111);

    // Ascending on the same keys: already ordered, nothing moves.
    send_beat(K1, TIDX, DIR_ASC);
    lat_check("t2", K1, TIDX, 1'b0, 4'b0000);

    // Ties and extremes.
    send_beat(64'h40200033_4010FF33, TIDX, DIR_ASC);
    lat_check("t3", 64'h4020FF33_40100033, 32'h76143250, 1'b0, 4'b0010);

    // Back-to-back stream with a three-cycle output stall in the middle.
    fork
      begin
        for (int b = 0; b < 6; b++)
          send_beat(rand_keys(), N*TW'($urandom()), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send_beat(rand_keys(), TIDX, DIR_DESC);
    send_beat(rand_keys(), TIDX, DIR_ASC);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst_out_valid", out_valid, 1'b0);
    chk("t5_rst_out_key",   out_key,   '0);
    chk("t5_rst_in_ready",  in_ready,  1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send_beat(K1, TIDX, DIR_DESC);
    lat_check("t5", 64'h04030201_05060708, 32'h32107654, 1'b1, 4'b1111);

    // Random stream with random gaps and random backpressure; sweeps run too.
    sweep_go = 1'b1;
    fork
      begin
        for (int b = 0; b < 300; b++) begin
          if ($urandom_range(0, 2) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          send_beat(rand_keys(), N*TW'($urandom()), 1'($urandom_range(0, 1)));
        end
        main_done = 1'b1;
      end
      begin
        while (!main_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("rand_drain");

    for (int w = 0; w < 30000 && !(sw[0].done && sw[1].done); w++) @(posedge clk);
    chk("sweep_done", {sw[0].done, sw[1].done}, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- configuration sweeps ----------------
  for (genvar g = 0; g < 2; g++) begin : sw
    localparam int S_NO = (g == 0) ? 1 : 5;
    localparam int S_PD = (g == 0) ? 4 : 1;
    localparam int S_N  = 2 ** S_NO;
    localparam int S_H  = S_N / 2;
    localparam int S_EW = S_N * (DW + TW) + 1 + S_H;

    logic               s_iv, s_ir, s_idir, s_ov, s_ordy, s_odir;
    logic [S_N*DW-1:0]  s_ik, s_ok;
    logic [S_N*TW-1:0]  s_it, s_ot;
    logic [S_H-1:0]     s_osw;
    logic [S_EW-1:0]    s_q[$];
    logic               done = 1'b0;
    int                 s_occ = 0;
    bit                 s_acc = 0, s_emi = 0, s_stall = 0;
    logic [S_EW-1:0]    s_prev;

    bitonic_node_pipe #(
      .DATA_WIDTH (DW), .TAG_WIDTH (TW), .NODE_ORDER (S_NO), .PIPE_DEPTH (S_PD)
    ) u_dut (
      .clk (clk), .reset (reset),
      .in_valid (s_iv), .in_ready (s_ir), .in_dir (s_idir),
      .in_key (s_ik), .in_tag (s_it),
      .out_valid (s_ov), .out_ready (s_ordy),
      .out_key (s_ok), .out_tag (s_ot), .out_dir (s_odir),
      .out_swap (s_osw)
    );

    function automatic logic [S_EW-1:0] s_model(input logic [S_N*DW-1:0] k,
                                                input logic [S_N*TW-1:0] t,
                                                input logic d);
      logic [S_N*DW-1:0] rk;
      logic [S_N*TW-1:0] rt;
      logic [S_H-1:0]    rs;
      int unsigned a, b;
      rk = k; rt = t; rs = '0;
      for (int i = 0; i < S_H; i++) begin
        a = k[i*DW +: DW];
        b = k[(i+S_H)*DW +: DW];
        if (d ? (b > a) : (a > b)) begin
          rk[i*DW +: DW]       = k[(i+S_H)*DW +: DW];
          rk[(i+S_H)*DW +: DW] = k[i*DW +: DW];
          rt[i*TW +: TW]       = t[(i+S_H)*TW +: TW];
          rt[(i+S_H)*TW +: TW] = t[i*TW +: TW];
          rs[i] = 1'b1;
        end
      end
      return {rk, rt, d, rs};
    endfunction

    initial begin
      s_iv = 1'b0; s_idir = 1'b0; s_ik = '0; s_it = '0;
      wait (sweep_go);
      @(posedge clk); #1;
      for (int b = 0; b < 1000; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_iv = 1'b0;
          repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
        s_iv   = 1'b1;
        s_idir = 1'($urandom_range(0, 1));
        for (int l = 0; l < S_N; l++) begin
          s_ik[l*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3))
                                                         : DW'($urandom_range(0, 255));
          s_it[l*TW +: TW] = TW'($urandom_range(0, 15));
        end
        @(negedge clk);
        for (int w = 0; w < 200 && !s_ir; w++) @(negedge clk);
        if (!s_ir) begin
          chk($sformatf("sw%0d_send_timeout", g), s_ir, 1'b1);
          break;
        end
        s_q.push_back(s_model(s_ik, s_it, s_idir));
        @(posedge clk); #1;
      end
      s_iv = 1'b0;
      for (int w = 0; w < 300 && s_q.size() != 0; w++) @(posedge clk);
      chk($sformatf("sw%0d_drain", g), s_q.size(), 0);
      done = 1'b1;
    end

    initial begin
      s_ordy = 1'b0;
      wait (sweep_go);
      while (!done) begin
        @(posedge clk); #1;
        s_ordy = ($urandom_range(0, 3) != 0);
      end
    end

    always @(negedge clk) begin
      logic [S_EW-1:0] act;
      act = {s_ok, s_ot, s_odir, s_osw};
      chk($sformatf("sw%0d_in_ready", g), s_ir, reset ? 1'b0 : !(s_occ == S_PD && !s_ordy));
      if (!reset && s_stall) chk($sformatf("sw%0d_stall_hold", g), act, s_prev);
      if (!reset && s_ov && s_ordy) begin
        if (s_q.size() == 0) chk($sformatf("sw%0d_spurious", g), s_ov, 1'b0);
        else chk($sformatf("sw%0d_beat", g), act, s_q.pop_front());
      end
      s_acc   = !reset && s_iv && s_ir;
      s_emi   = !reset && s_ov && s_ordy;
      s_stall = !reset && s_ov && !s_ordy;
      s_prev  = act;
    end

    always @(posedge clk) begin
      if (reset) s_occ = 0;
      else s_occ = s_occ + int'(s_acc) - int'(s_emi);
    end
  end

endmodule
